keynsham_uart_bus_master: RTL and testbench
===========================================

Name: keynsham_uart_bus_master

Overview:
- UART-driven bus initiator (debug bridge) for the keynsham bus; the initiator end of the bus that UART/peripheral responders sit on.
- Consumes command bytes from a uart receiver byte interface, issues one 32-bit bus read or write, and returns status/data bytes through the uart transmitter byte interface.
- Sits beside the CPU data master. An external arbiter grants the bus; the arbiter is outside this block.

Parameters:
ack_timeout, 1024, bus cycles to wait for bus_ack/bus_error before aborting (range 2..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
rx_data  in  8  received byte from uart
rx_rdy  in  1  level: rx_data valid
rx_rdy_clr  out  1  one-cycle pulse: byte consumed
tx_din  out  8  byte to transmit
tx_wr_en  out  1  one-cycle pulse: start transmit of tx_din
tx_busy  in  1  uart transmitter busy
bus_access  out  1  transaction request, held until completion
bus_addr  out  30  word address (byte address [31:2])
bus_wr_val  out  32  write data
bus_wr_en  out  1  1 = write, 0 = read
bus_bytesel  out  4  byte lanes, always 4'b1111 during access
bus_ack  in  1  transaction complete
bus_error  in  1  transaction failed
bus_data  in  32  read data, valid with bus_ack
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: the only reset is the single asynchronous active-low rst_n. On assertion, all outputs go to 0, state goes to IDLE, and counters are cleared. Reset mid-frame or mid-bus-access aborts immediately and sends no response.
- Frame format (all multi-byte fields big-endian):
  - CMD: 8'h01 = read word, 8'h02 = write word.
  - 4 address bytes follow CMD.
  - Write frames carry 4 data bytes after the address.
  - Address bits [1:0] are ignored.
- Response: one status byte.
  - Status codes: 8'h00 ok, 8'h01 bus error, 8'h02 timeout, 8'h03 bad command.
  - A successful read appends 4 data bytes, MSB first. No data bytes follow any other status.
- RX rule: in a receive state, if rx_rdy=1 and rx_rdy_clr was 0 last cycle:
  - capture rx_data;
  - pulse rx_rdy_clr for exactly 1 cycle.
  - rx_rdy is not sampled on the cycle after a pulse.
- TX rule:
  - Drive tx_din and pulse tx_wr_en for 1 cycle, only when tx_busy=0.
  - The next byte is not issued until tx_busy has been seen 1 and then 0.
  - tx_din is held stable until that point.
- States and transitions:
  - IDLE: wait for a byte. 01/02 go to ADDR (byte_cnt=0). Any other value latches status 03 and goes to RESP_STATUS.
  - ADDR: shift in 4 bytes. After the 4th byte, read goes to BUS and write goes to DATA.
  - DATA: shift in 4 bytes, then go to BUS.
  - BUS:
    - On entry, register bus_access=1, bus_addr, bus_wr_en, bus_wr_val and bytesel=4'hf; all are held stable.
    - Timeout counter counts from 0 on each cycle bus_access is high.
    - Sample bus_error/bus_ack every cycle. bus_error=1 means status 01; this covers the case where both are high in the same cycle, because error wins.
    - bus_ack=1 means status 00, and a read latches bus_data.
    - If the counter reaches ack_timeout-1 with neither input seen, status is 02. If ack arrives on that same cycle, ack wins.
    - bus_access drops on the cycle after completion. Then go to RESP_STATUS.
  - RESP_STATUS: send the status byte. If status=00 and the command was a read, go to RESP_DATA; otherwise go to IDLE.
  - RESP_DATA: send 4 latched bytes [31:24]..[7:0], then go to IDLE.
- Latency: bus_access rises 1 cycle after the last frame byte is captured.
- Bytes received while in BUS/RESP states are not consumed; they stay pending in the uart.
- No inter-byte timeout. The host must send well-formed frames. A bad command resynchronises the framing at its status byte.
- Exactly one bus transaction is in flight per frame. bus_wr_en and bus_addr change only when bus_access=0.

Decomposition:
- Shared include (keynsham defines file):
  - `DBG_CMD_READ 8'h01 and `DBG_CMD_WRITE 8'h02.
  - `DBG_STATUS_OK 8'h00, `DBG_STATUS_BUSERR 8'h01, `DBG_STATUS_TIMEOUT 8'h02, `DBG_STATUS_BADCMD 8'h03.
  - State encodings.
- Single module. No sub-module is natural; the timeout counter and byte shifters are small and inline.

Test Plan:
- Read: bytes 01 00 00 10 04 with the responder acking in 1 cycle with 32'hDEADBEEF -> bus_addr=30'h401, bus_wr_en=0, bytesel=f. TX sends 00 DE AD BE EF.
- Write: bytes 02 00 00 20 00 12 34 56 78 -> one access with bus_wr_en=1, bus_wr_val=32'h12345678, bus_addr=30'h800. TX sends 00 only.
- Error/precedence: bus_error and bus_ack both high on the same cycle -> TX 01, no data bytes, bus_access low the next cycle.
- Timeout: ack_timeout=8, responder never acks -> bus_access high for exactly 8 cycles, TX 02. Ack on the 8th cycle instead -> TX 00.
- Bad command and back-pressure: byte 55 -> TX 03 and IDLE; a following valid read frame works. tx_busy held high for 100 cycles -> tx_wr_en not re-pulsed and tx_din stable.
- Reset mid-access: drop rst_n while bus_access=1 -> all outputs 0 immediately (asynchronously), busy=0, nothing transmitted after release.

Source files
------------

// File: rtl/keynsham_uart_bus_master_pkg.sv
// Shared definitions for the keynsham UART debug bus master.
// Holds the frame command codes, response status codes and FSM state encodings.
// Ports: none (package only).
package keynsham_uart_bus_master_pkg;

  localparam logic [7:0] DBG_CMD_READ       = 8'h01;
  localparam logic [7:0] DBG_CMD_WRITE      = 8'h02;

  localparam logic [7:0] DBG_STATUS_OK      = 8'h00;
  localparam logic [7:0] DBG_STATUS_BUSERR  = 8'h01;
  localparam logic [7:0] DBG_STATUS_TIMEOUT = 8'h02;
  localparam logic [7:0] DBG_STATUS_BADCMD  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ADDR        = 3'd1,
    ST_DATA        = 3'd2,
    ST_BUS         = 3'd3,
    ST_RESP_STATUS = 3'd4,
    ST_RESP_DATA   = 3'd5
  } state_t;

endpackage

// File: rtl/keynsham_uart_bus_master.sv
// UART-driven debug bus initiator: parses read/write frames from the uart receiver,
// issues one 32-bit keynsham bus access per frame, and returns status (+ read data) bytes.
// Ports: clk/rst_n; uart rx byte i/f (rx_data, rx_rdy, rx_rdy_clr); uart tx byte i/f
// (tx_din, tx_wr_en, tx_busy); bus initiator (bus_access .. bus_data); busy = not idle.
module keynsham_uart_bus_master
  import keynsham_uart_bus_master_pkg::*;
#(
  parameter int unsigned ack_timeout = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        rx_rdy_clr,
  output logic [7:0]  tx_din,
  output logic        tx_wr_en,
  input  logic        tx_busy,
  output logic        bus_access,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_val,
  output logic        bus_wr_en,
  output logic [3:0]  bus_bytesel,
  input  logic        bus_ack,
  input  logic        bus_error,
  input  logic [31:0] bus_data,
  output logic        busy
);

  localparam logic [15:0] TMO_LAST = 16'(ack_timeout - 1);

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic        cmd_wr, cmd_wr_nxt;
  logic [23:0] addr_hi, addr_hi_nxt;
  logic [31:0] data_sr, data_sr_nxt;   // write data while receiving, read data while replying
  logic [7:0]  status, status_nxt;
  logic [15:0] tmo_cnt, tmo_cnt_nxt;
  logic        tx_inflight, tx_inflight_nxt;
  logic        tx_seen_busy, tx_seen_busy_nxt;

  logic        rx_rdy_clr_nxt, tx_wr_en_nxt, bus_access_nxt, bus_wr_en_nxt;
  logic [7:0]  tx_din_nxt;
  logic [29:0] bus_addr_nxt;
  logic [31:0] bus_wr_val_nxt;
  logic [3:0]  bus_bytesel_nxt;

  logic rx_take, tx_can_issue, tx_done;

  // The uart needs a cycle to drop rx_rdy after our clear pulse, so never
  // sample it in the cycle the pulse is out.
  assign rx_take      = rx_rdy && !rx_rdy_clr;
  // A byte is finished only once the transmitter has gone busy and come back.
  assign tx_can_issue = !tx_inflight && !tx_busy;
  assign tx_done      = tx_inflight && tx_seen_busy && !tx_busy;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      cmd_wr       <= 1'b0;
      addr_hi      <= '0;
      data_sr      <= '0;
      status       <= '0;
      tmo_cnt      <= '0;
      tx_inflight  <= 1'b0;
      tx_seen_busy <= 1'b0;
      rx_rdy_clr   <= 1'b0;
      tx_din       <= '0;
      tx_wr_en     <= 1'b0;
      bus_access   <= 1'b0;
      bus_addr     <= '0;
      bus_wr_val   <= '0;
      bus_wr_en    <= 1'b0;
      bus_bytesel  <= '0;
    end else begin
      state        <= state_nxt;
      byte_cnt     <= byte_cnt_nxt;
      cmd_wr       <= cmd_wr_nxt;
      addr_hi      <= addr_hi_nxt;
      data_sr      <= data_sr_nxt;
      status       <= status_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      tx_inflight  <= tx_inflight_nxt;
      tx_seen_busy <= tx_seen_busy_nxt;
      rx_rdy_clr   <= rx_rdy_clr_nxt;
      tx_din       <= tx_din_nxt;
      tx_wr_en     <= tx_wr_en_nxt;
      bus_access   <= bus_access_nxt;
      bus_addr     <= bus_addr_nxt;
      bus_wr_val   <= bus_wr_val_nxt;
      bus_wr_en    <= bus_wr_en_nxt;
      bus_bytesel  <= bus_bytesel_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    byte_cnt_nxt     = byte_cnt;
    cmd_wr_nxt       = cmd_wr;
    addr_hi_nxt      = addr_hi;
    data_sr_nxt      = data_sr;
    status_nxt       = status;
    tmo_cnt_nxt      = tmo_cnt;
    tx_inflight_nxt  = tx_inflight;
    tx_seen_busy_nxt = tx_seen_busy;
    rx_rdy_clr_nxt   = 1'b0;
    tx_din_nxt       = tx_din;
    tx_wr_en_nxt     = 1'b0;
    bus_access_nxt   = bus_access;
    bus_addr_nxt     = bus_addr;
    bus_wr_val_nxt   = bus_wr_val;
    bus_wr_en_nxt    = bus_wr_en;
    bus_bytesel_nxt  = bus_bytesel;

    if (tx_inflight && tx_busy) tx_seen_busy_nxt = 1'b1;
    if (tx_done) begin
      tx_inflight_nxt  = 1'b0;
      tx_seen_busy_nxt = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (rx_take) begin
          rx_rdy_clr_nxt = 1'b1;
          byte_cnt_nxt   = '0;
          if (rx_data == DBG_CMD_READ || rx_data == DBG_CMD_WRITE) begin
            cmd_wr_nxt = (rx_data == DBG_CMD_WRITE);
            state_nxt  = ST_ADDR;
          end else begin
            status_nxt = DBG_STATUS_BADCMD;
            state_nxt  = ST_RESP_STATUS;
          end
        end
      end

      ST_ADDR: begin
        if (rx_take) begin
          rx_rdy_clr_nxt = 1'b1;
          byte_cnt_nxt   = byte_cnt + 2'd1;
          addr_hi_nxt    = {addr_hi[15:0], rx_data};
          if (byte_cnt == 2'd3) begin
            // Last address byte: bits [1:0] drop out of the word address here.
            bus_addr_nxt = {addr_hi, rx_data[7:2]};
            state_nxt    = cmd_wr ? ST_DATA : ST_BUS;
          end
        end
      end

      ST_DATA: begin
        if (rx_take) begin
          rx_rdy_clr_nxt = 1'b1;
          byte_cnt_nxt   = byte_cnt + 2'd1;
          data_sr_nxt    = {data_sr[23:0], rx_data};
          if (byte_cnt == 2'd3) state_nxt = ST_BUS;
        end
      end

      ST_BUS: begin
        if (!bus_access) begin
          bus_access_nxt  = 1'b1;
          bus_wr_en_nxt   = cmd_wr;
          bus_wr_val_nxt  = data_sr;
          bus_bytesel_nxt = 4'hf;
          tmo_cnt_nxt     = '0;
        end else begin
          // Error outranks ack; ack outranks a timeout landing on the same cycle.
          if (bus_error || bus_ack || tmo_cnt == TMO_LAST) begin
            bus_access_nxt  = 1'b0;
            bus_bytesel_nxt = '0;
            state_nxt       = ST_RESP_STATUS;
          end
          if (bus_error) begin
            status_nxt = DBG_STATUS_BUSERR;
          end else if (bus_ack) begin
            status_nxt = DBG_STATUS_OK;
            if (!cmd_wr) data_sr_nxt = bus_data;
          end else if (tmo_cnt == TMO_LAST) begin
            status_nxt = DBG_STATUS_TIMEOUT;
          end else begin
            tmo_cnt_nxt = tmo_cnt + 16'd1;
          end
        end
      end

      ST_RESP_STATUS: begin
        if (tx_can_issue) begin
          tx_din_nxt       = status;
          tx_wr_en_nxt     = 1'b1;
          tx_inflight_nxt  = 1'b1;
          tx_seen_busy_nxt = 1'b0;
        end else if (tx_done) begin
          byte_cnt_nxt = '0;
          state_nxt    = (status == DBG_STATUS_OK && !cmd_wr) ? ST_RESP_DATA : ST_IDLE;
        end
      end

      ST_RESP_DATA: begin
        if (tx_can_issue) begin
          tx_din_nxt       = data_sr[31:24];
          tx_wr_en_nxt     = 1'b1;
          tx_inflight_nxt  = 1'b1;
          tx_seen_busy_nxt = 1'b0;
        end else if (tx_done) begin
          data_sr_nxt  = {data_sr[23:0], 8'h00};
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_keynsham_uart_bus_master.sv
module tb_keynsham_uart_bus_master;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        rx_rdy_clr;
  logic [7:0]  tx_din;
  logic        tx_wr_en;
  logic        tx_busy;
  logic        bus_access;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_val;
  logic        bus_wr_en;
  logic [3:0]  bus_bytesel;
  logic        bus_ack = 1'b0;
  logic        bus_error = 1'b0;
  logic [31:0] bus_data = 32'h0;
  logic        busy;

  keynsham_uart_bus_master #(.ack_timeout(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rdy_clr(rx_rdy_clr),
    .tx_din(tx_din), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
    .bus_access(bus_access), .bus_addr(bus_addr), .bus_wr_val(bus_wr_val),
    .bus_wr_en(bus_wr_en), .bus_bytesel(bus_bytesel), .bus_ack(bus_ack),
    .bus_error(bus_error), .bus_data(bus_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  logic [78:0] outs;
  assign outs = {rx_rdy_clr, tx_din, tx_wr_en, bus_access, bus_addr, bus_wr_val,
                 bus_wr_en, bus_bytesel, busy};

  // ---------------- uart transmitter model ----------------
  int   busy_cnt = 0;
  logic busy_m = 1'b0;
  logic hold_busy = 1'b0;
  assign tx_busy = busy_m | hold_busy;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      busy_m   = 1'b0;
    end else begin
      if (tx_wr_en === 1'b1) begin
        tests++;
        if (tx_busy !== 1'b0) begin
          fails++;
          $display("FAIL tx_pulse_while_busy: tx_wr_en=1 with tx_busy=%b, required tx_busy=0", tx_busy);
        end
        tx_q.push_back(tx_din);
        busy_cnt = 3;
      end
      busy_m = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  // ---------------- bus responder model ----------------
  int          resp_delay = 1;
  logic        resp_err = 1'b0;
  logic        resp_never = 1'b0;
  int          acc_cycles = 0;
  int          acc_len = 0;
  int          n_acc = 0;
  int          stab_err = 0;
  logic [29:0] a_addr;
  logic [31:0] a_val;
  logic        a_wr;
  logic [3:0]  a_sel;

  always @(negedge clk) begin
    bus_ack   = 1'b0;
    bus_error = 1'b0;
    if (bus_access === 1'b1) begin
      if (acc_cycles == 0) begin
        a_addr = bus_addr; a_val = bus_wr_val; a_wr = bus_wr_en; a_sel = bus_bytesel;
        n_acc++;
      end else if (bus_addr !== a_addr || bus_wr_val !== a_val ||
                   bus_wr_en !== a_wr || bus_bytesel !== a_sel) begin
        stab_err++;
      end
      acc_cycles++;
      acc_len = acc_cycles;
      if (!resp_never && acc_cycles == resp_delay) begin
        bus_ack   = 1'b1;
        bus_error = resp_err;
      end
    end else begin
      acc_cycles = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    t = 0;
    @(negedge clk);
    while (rx_rdy_clr !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= 200) begin
      fails++;
      $display("FAIL rx_consume: byte %02h not consumed after %0d cycles, required rx_rdy_clr pulse", b, t);
    end
    rx_rdy = 1'b0;
  endtask

  task automatic send_bytes(input bq_t bs);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic expect_resp(input string name);
    int t;
    logic [7:0] e, a;
    t = 0;
    while (tx_q.size() < exp_q.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (tx_q.size() == 0) begin
        fails++;
        $display("FAIL %s_tx_missing: no byte transmitted, required %02h", name, e);
      end else begin
        a = tx_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL %s_tx_byte: got %02h, required %02h", name, a, e);
        end
      end
    end
    repeat (20) @(negedge clk);
    tests++;
    if (tx_q.size() != 0) begin
      fails++;
      $display("FAIL %s_tx_extra: %0d extra bytes (first %02h), required 0", name, tx_q.size(), tx_q[0]);
    end
    tx_q.delete();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: busy=%b, required 0", name, busy);
    end
  endtask

  task automatic check_access(input string name, input logic [29:0] addr, input logic wr,
                              input logic [31:0] val, input int n_before, input int len);
    tests++;
    if (n_acc !== n_before + 1) begin
      fails++;
      $display("FAIL %s_acc_count: %0d accesses, required 1", name, n_acc - n_before);
    end
    tests++;
    if (a_addr !== addr || a_wr !== wr || a_sel !== 4'hf) begin
      fails++;
      $display("FAIL %s_acc_fields: addr=%h wr=%b sel=%h, required addr=%h wr=%b sel=f",
               name, a_addr, a_wr, a_sel, addr, wr);
    end
    if (wr) begin
      tests++;
      if (a_val !== val) begin
        fails++;
        $display("FAIL %s_acc_wdata: %h, required %h", name, a_val, val);
      end
    end
    tests++;
    if (acc_len !== len) begin
      fails++;
      $display("FAIL %s_acc_len: bus_access high %0d cycles, required %0d", name, acc_len, len);
    end
    tests++;
    if (stab_err !== 0) begin
      fails++;
      $display("FAIL %s_acc_stable: %0d unstable cycles, required 0", name, stab_err);
      stab_err = 0;
    end
  endtask

  function automatic bq_t read_frame(input logic [31:0] addr);
    bq_t q;
    q = '{8'h01, addr[31:24], addr[23:16], addr[15:8], addr[7:0]};
    return q;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_outputs: %h, required 0", outs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    int n0;
    n0 = n_acc;
    resp_delay = 1; resp_err = 1'b0; resp_never = 1'b0;
    bus_data = 32'hDEADBEEF;
    exp_q = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_bytes('{8'h01, 8'h00, 8'h00, 8'h10, 8'h04});
    expect_resp("read");
    check_access("read", 30'h401, 1'b0, 32'h0, n0, 1);
  endtask

  task automatic test_write();
    int n0;
    n0 = n_acc;
    resp_delay = 2; resp_err = 1'b0; resp_never = 1'b0;
    exp_q = '{8'h00};
    send_bytes('{8'h02, 8'h00, 8'h00, 8'h20, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78});
    expect_resp("write");
    check_access("write", 30'h800, 1'b1, 32'h12345678, n0, 2);
  endtask

  task automatic test_error_precedence();
    int n0;
    n0 = n_acc;
    resp_delay = 1; resp_err = 1'b1; resp_never = 1'b0;
    bus_data = 32'h55AA55AA;
    exp_q = '{8'h01};
    send_bytes(read_frame(32'h0000_0040));
    expect_resp("buserr");
    check_access("buserr", 30'h010, 1'b0, 32'h0, n0, 1);
    resp_err = 1'b0;
  endtask

  task automatic test_timeout();
    int n0;
    n0 = n_acc;
    resp_never = 1'b1;
    exp_q = '{8'h02};
    send_bytes(read_frame(32'hFFFF_FFFC));
    expect_resp("timeout");
    check_access("timeout", 30'h3FFFFFFF, 1'b0, 32'h0, n0, 8);
    // Ack on the last counted cycle beats the timeout; low address bits ignored.
    n0 = n_acc;
    resp_never = 1'b0; resp_delay = 8;
    bus_data = 32'h0BADF00D;
    exp_q = '{8'h00, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
    send_bytes(read_frame(32'h0000_0107));
    expect_resp("late_ack");
    check_access("late_ack", 30'h041, 1'b0, 32'h0, n0, 8);
  endtask

  task automatic test_bad_command();
    int n0;
    n0 = n_acc;
    exp_q = '{8'h03};
    send_byte(8'h55);
    expect_resp("badcmd");
    tests++;
    if (n_acc !== n0) begin
      fails++;
      $display("FAIL badcmd_no_access: %0d accesses, required 0", n_acc - n0);
    end
    resp_delay = 2; bus_data = 32'h01020304;
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(read_frame(32'h1234_5678));
    expect_resp("after_bad");
    check_access("after_bad", 30'h048D159E, 1'b0, 32'h0, n0, 2);
  endtask

  task automatic test_backpressure();
    int t, pulses, changes;
    logic [7:0] held;
    resp_delay = 3; bus_data = 32'hCAFEF00D;
    exp_q = '{8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_bytes(read_frame(32'h0000_0800));
    t = 0;
    while (tx_q.size() < 1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    hold_busy = 1'b1;
    held = tx_din;
    pulses = 0; changes = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_wr_en !== 1'b0) pulses++;
      if (tx_din !== held) changes++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL bp_no_pulse: %0d tx_wr_en pulses while busy, required 0", pulses);
    end
    tests++;
    if (changes != 0 || held !== 8'h00) begin
      fails++;
      $display("FAIL bp_din_stable: held=%02h changes=%0d, required 00 and 0", held, changes);
    end
    hold_busy = 1'b0;
    expect_resp("backpressure");
  endtask

  task automatic test_reset_mid_access();
    int t;
    resp_never = 1'b1;
    send_bytes(read_frame(32'h0000_0020));
    t = 0;
    while (bus_access !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (bus_access !== 1'b1) begin
      fails++;
      $display("FAIL midrst_access: bus_access=%b, required 1", bus_access);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: %h, required 0", outs);
    end
    resp_never = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_q.delete();
    repeat (50) @(negedge clk);
    tests++;
    if (tx_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_silent: %0d bytes sent, busy=%b, required 0 and 0", tx_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_error_precedence();
    test_timeout();
    test_bad_command();
    test_backpressure();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
